// File: rtl/mult_share_arb_if.sv
// Request/result bundle between requesters, consumer and the shared-multiplier arbiter.
interface mult_share_arb_if #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic           res_ready;
    logic [IDW-1:0] res_id;
    logic [2*W-1:0] res_p;
    logic           busy;

    modport master (
        output req, a_flat, b_flat, res_ready,
        input  gnt, res_valid, res_id, res_p, busy
    );

    modport slave (
        input  req, a_flat, b_flat, res_ready,
        output gnt, res_valid, res_id, res_p, busy
    );
endinterface

// File: rtl/mult_share_arb.sv
// Time-shares one combinational W x W multiplier among N requesters (IDLE -> MUL -> HOLD).
// Define MULT_SHARE_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module unsigned_parallel_multiplier #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);
    logic [2*W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (y[i]) acc = acc + ({{W{1'b0}}, x} << i);
        end
        p = acc;
    end
endmodule

module mult_share_arb #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_arb_if.slave  bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    typedef logic [IDW-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    idx_t           idx;
    logic [2*W-1:0] prod;

    idx_t           win;
    logic           found;
    logic [N-1:0]   win_oh;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

`ifdef MULT_SHARE_RR_EN
    idx_t           ptr;
    int unsigned    cand;

    // Search starts at ptr and wraps modulo N, so N need not be a power of two.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!found && bus.req[cand]) begin
                win   = idx_t'(cand);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && bus.req[k]) begin
                win   = idx_t'(k);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (win == idx_t'(k)) begin
                win_oh[k] = 1'b1;
                sel_a     = bus.a_flat[k*W +: W];
                sel_b     = bus.b_flat[k*W +: W];
            end
        end
    end

    unsigned_parallel_multiplier #(.W(W)) u_mul (
        .x (op_a),
        .y (op_b),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_a          <= '0;
            op_b          <= '0;
            idx           <= '0;
            bus.gnt       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_p     <= '0;
            bus.busy      <= 1'b0;
`ifdef MULT_SHARE_RR_EN
            ptr           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a     <= sel_a;
                        op_b     <= sel_b;
                        idx      <= win;
                        bus.gnt  <= win_oh;
                        bus.busy <= 1'b1;
                        state    <= MUL;
`ifdef MULT_SHARE_RR_EN
                        ptr      <= (win == idx_t'(N-1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                MUL: begin
                    bus.res_p     <= prod;
                    bus.res_id    <= idx;
                    bus.res_valid <= 1'b1;
                    bus.gnt       <= '0;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.gnt       <= '0;
                    bus.res_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb (W=4, N=4), both arbitration builds.
module tb_mult_share_arb;
    localparam int unsigned W = 4;
    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mult_share_arb_if #(.W(W), .N(N)) bus ();

    mult_share_arb #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef MULT_SHARE_RR_EN
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
`else
    int exp_order [6] = '{0, 0, 0, 0, 0, 0};
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_flat[i*W +: W] = a;
        bus.b_flat[i*W +: W] = b;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.a_flat    = '0;
        bus.b_flat    = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid); end
        n_cmp++; if (bus.res_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", bus.res_id); end
        n_cmp++; if (bus.res_p !== 8'd0) begin n_err++; $display("FAIL reset_p: got %0d expected 0", bus.res_p); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        set_ops(2, 4'd2, 4'd4);
        bus.req       = 4'b0100;
        bus.res_ready = 1'b1;
        step();
        n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL basic_gnt: got %b expected 0100", bus.gnt); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b expected 0", bus.res_valid); end
        bus.req = '0;
        step();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL basic_gnt_pulse: got %b expected 0000", bus.gnt); end
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", bus.res_valid); end
        n_cmp++; if (bus.res_id !== 2'd2) begin n_err++; $display("FAIL basic_id: got %0d expected 2", bus.res_id); end
        n_cmp++; if (bus.res_p !== 8'd8) begin n_err++; $display("FAIL basic_p: got %0d expected 8", bus.res_p); end
        step();
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL basic_accept: got %b expected 0", bus.res_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_corner();
        logic [W-1:0]   ta [3] = '{4'd15, 4'd15, 4'd0};
        logic [W-1:0]   tb [3] = '{4'd3,  4'd15, 4'd15};
        logic [2*W-1:0] tp [3] = '{8'd45, 8'd225, 8'd0};
        bus.res_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            set_ops(0, ta[v], tb[v]);
            bus.req = 4'b0001;
            step();
            n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL corner%0d_gnt: got %b expected 0001", v, bus.gnt); end
            bus.req = '0;
            step();
            n_cmp++; if (bus.res_p !== tp[v]) begin n_err++; $display("FAIL corner%0d_p: got %0d expected %0d", v, bus.res_p, tp[v]); end
            n_cmp++; if (bus.res_id !== 2'd0) begin n_err++; $display("FAIL corner%0d_id: got %0d expected 0", v, bus.res_id); end
            step();
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL corner%0d_idle: got %b expected 0", v, bus.busy); end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_oh;
        int           w;
        for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 1), 4'd3);
        bus.res_ready = 1'b1;
        bus.req       = 4'b1011;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (bus.gnt === 4'b0000 && w < 8) begin
                step();
                w++;
            end
            exp_oh = 4'b0001 << exp_order[g];
            n_cmp++; if (bus.gnt !== exp_oh) begin n_err++; $display("FAIL contention_gnt%0d: got %b expected %b", g, bus.gnt, exp_oh); end
            if (g == 5) bus.req = '0;
            step();
            n_cmp++; if (bus.res_id !== 2'(exp_order[g])) begin n_err++; $display("FAIL contention_id%0d: got %0d expected %0d", g, bus.res_id, exp_order[g]); end
            n_cmp++; if (bus.res_p !== 8'((exp_order[g] + 1) * 3)) begin n_err++; $display("FAIL contention_p%0d: got %0d expected %0d", g, bus.res_p, (exp_order[g] + 1) * 3); end
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        set_ops(0, 4'd7, 4'd9);
        set_ops(1, 4'd5, 4'd6);
        bus.req = 4'b0001;
        step();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL bp_gnt0: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0010;
        step();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd63) begin n_err++; $display("FAIL bp_first: valid %b p %0d expected 1 63", bus.res_valid, bus.res_p); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== 8'd63 || bus.busy !== 1'b1 || bus.gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid %b id %0d p %0d busy %b gnt %b expected 1 0 63 1 0000",
                         c, bus.res_valid, bus.res_id, bus.res_p, bus.busy, bus.gnt);
            end
        end
        bus.res_ready = 1'b1;
        step();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_err++; $display("FAIL bp_release: valid %b busy %b gnt %b expected 0 0 0000", bus.res_valid, bus.busy, bus.gnt); end
        step();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL bp_gnt1: got %b expected 0010", bus.gnt); end
        bus.req = '0;
        step();
        n_cmp++; if (bus.res_id !== 2'd1 || bus.res_p !== 8'd30) begin n_err++; $display("FAIL bp_result1: id %0d p %0d expected 1 30", bus.res_id, bus.res_p); end
        step();
    endtask

    task automatic test_back_to_back();
        int           w;
        int           interval;
        logic [N-1:0] exit_gnt;
        bus.res_ready = 1'b1;
        set_ops(0, 4'd4, 4'd4);
        bus.req = 4'b0001;
        w = 0;
        while (bus.gnt !== 4'b0001 && w < 8) begin
            step();
            w++;
        end
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL b2b_first_gnt: got %b expected 0001", bus.gnt); end
        interval = 0;
        exit_gnt = 'x;
        do begin
            step();
            interval++;
            if (interval == 1) begin
                n_cmp++; if (bus.res_p !== 8'd16) begin n_err++; $display("FAIL b2b_p: got %0d expected 16", bus.res_p); end
            end
            if (interval == 2) exit_gnt = bus.gnt;
        end while (bus.gnt !== 4'b0001 && interval < 8);
        n_cmp++; if (exit_gnt !== 4'b0000) begin n_err++; $display("FAIL b2b_exit_gnt: got %b expected 0000", exit_gnt); end
        n_cmp++; if (interval != 3) begin n_err++; $display("FAIL b2b_interval: got %0d expected 3", interval); end
        bus.req = '0;
        step();
        step();
    endtask

    task automatic test_reset_mid_hold();
        bus.res_ready = 1'b0;
        set_ops(3, 4'd3, 4'd5);
        bus.req = 4'b1000;
        step();
        bus.req = '0;
        step();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd15 || bus.res_id !== 2'd3) begin n_err++; $display("FAIL rst_pre: valid %b p %0d id %0d expected 1 15 3", bus.res_valid, bus.res_p, bus.res_id); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.res_p !== 8'd0 || bus.res_id !== 2'd0 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: valid %b p %0d id %0d gnt %b busy %b expected all 0",
                     bus.res_valid, bus.res_p, bus.res_id, bus.gnt, bus.busy);
        end
        #2;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_idle%0d: busy %b gnt %b valid %b expected 0 0000 0", c, bus.busy, bus.gnt, bus.res_valid);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_corner();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
